// File: rtl/y86_iram_loader.sv
// Host byte-stream loader for the y86 IRAM: parses SYNC/ADDR/LEN/payload frames into byte writes
// and holds the CPU in reset until the first good frame. Define Y86_LOADER_CHECKSUM_EN for a trailing CSUM byte.
module y86_iram_loader #(
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5,
  parameter logic [31:0] ADDR_LIMIT = 32'h0000_1000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic        mem_ready,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_LEN, S_DATA, S_CSUM, S_DONE, S_ERR
  } state_t;

  state_t      state, state_n;
  logic [1:0]  byte_cnt, byte_cnt_n;
  logic [31:0] base, base_n;
  logic [7:0]  len_lo, len_lo_n;
  logic [15:0] remaining, remaining_n;
  logic [15:0] index, index_n;
  logic        ready_en;
  logic        mem_we_n;
  logic [31:0] mem_addr_n;
  logic [7:0]  mem_wdata_n;
  logic        cpu_hold_n;
  logic        load_done_n;
  logic        load_err_n;
  logic        payload_end;
  logic        frame_ok;
`ifdef Y86_LOADER_CHECKSUM_EN
  logic [7:0]  sum, sum_n;
`endif

  logic [15:0] len_full;
  logic        out_of_range;
  logic        write_busy;
  logic        xfer;

  // Little-endian LEN completes with the high byte; range check is 33 bits so it cannot wrap.
  assign len_full     = {rx_data, len_lo};
  assign out_of_range = ({1'b0, base} + {17'd0, len_full}) > {1'b0, ADDR_LIMIT};
  assign write_busy   = mem_we && !mem_ready;

  // Payload bytes stall while a write is outstanding or all bytes are already in.
  assign rx_ready = ready_en &&
                    ((state == S_DATA) ? (!write_busy && remaining != 16'd0)
                                       : (state != S_DONE));
  assign xfer     = rx_valid && rx_ready;

  always_comb begin
    state_n     = state;
    byte_cnt_n  = byte_cnt;
    base_n      = base;
    len_lo_n    = len_lo;
    remaining_n = remaining;
    index_n     = index;
    mem_we_n    = mem_we;
    mem_addr_n  = mem_addr;
    mem_wdata_n = mem_wdata;
    cpu_hold_n  = cpu_hold;
    load_done_n = 1'b0;
    load_err_n  = load_err;
    payload_end = 1'b0;
    frame_ok    = 1'b0;
`ifdef Y86_LOADER_CHECKSUM_EN
    sum_n       = sum;
`endif

    case (state)
      S_IDLE: begin
        if (xfer && rx_data == SYNC_BYTE) begin
          state_n    = S_ADDR;
          byte_cnt_n = 2'd0;
        end
      end

      S_ADDR: begin
        if (xfer) begin
          base_n = {rx_data, base[31:8]};
          if (byte_cnt == 2'd3) begin
            state_n    = S_LEN;
            byte_cnt_n = 2'd0;
          end else begin
            byte_cnt_n = byte_cnt + 2'd1;
          end
        end
      end

      S_LEN: begin
        if (xfer) begin
          len_lo_n = rx_data;
          if (byte_cnt == 2'd1) begin
            byte_cnt_n = 2'd0;
            if (out_of_range) begin
              state_n    = S_ERR;
              load_err_n = 1'b1;
            end else if (len_full == 16'd0) begin
              payload_end = 1'b1;
            end else begin
              state_n     = S_DATA;
              remaining_n = len_full;
              index_n     = 16'd0;
            end
          end else begin
            byte_cnt_n = 2'd1;
          end
        end
      end

      S_DATA: begin
        if (mem_we && mem_ready)
          mem_we_n = 1'b0;
        if (xfer) begin
          mem_we_n    = 1'b1;
          mem_addr_n  = base + {16'd0, index};
          mem_wdata_n = rx_data;
          index_n     = index + 16'd1;
          remaining_n = remaining - 16'd1;
`ifdef Y86_LOADER_CHECKSUM_EN
          sum_n       = sum + rx_data;
`endif
        end else if (remaining == 16'd0 && !write_busy) begin
          mem_we_n    = 1'b0;
          payload_end = 1'b1;
        end
      end

`ifdef Y86_LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (xfer) begin
          if (rx_data == sum) begin
            frame_ok = 1'b1;
          end else begin
            state_n    = S_ERR;
            load_err_n = 1'b1;
          end
        end
      end
`endif

      S_DONE: begin
        state_n     = S_IDLE;
        byte_cnt_n  = 2'd0;
        index_n     = 16'd0;
        remaining_n = 16'd0;
`ifdef Y86_LOADER_CHECKSUM_EN
        sum_n       = 8'd0;
`endif
      end

      S_ERR: begin
        mem_we_n = 1'b0;
      end

      default: state_n = S_IDLE;
    endcase

`ifdef Y86_LOADER_CHECKSUM_EN
    if (payload_end)
      state_n = S_CSUM;
`else
    if (payload_end)
      frame_ok = 1'b1;
`endif

    // A good frame releases the CPU for good; later frames reload under a running CPU.
    if (frame_ok) begin
      state_n     = S_DONE;
      load_done_n = 1'b1;
      cpu_hold_n  = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= S_IDLE;
      byte_cnt  <= 2'd0;
      base      <= 32'd0;
      len_lo    <= 8'd0;
      remaining <= 16'd0;
      index     <= 16'd0;
      ready_en  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 8'd0;
      cpu_hold  <= 1'b1;
      load_done <= 1'b0;
      load_err  <= 1'b0;
`ifdef Y86_LOADER_CHECKSUM_EN
      sum       <= 8'd0;
`endif
    end else begin
      state     <= state_n;
      byte_cnt  <= byte_cnt_n;
      base      <= base_n;
      len_lo    <= len_lo_n;
      remaining <= remaining_n;
      index     <= index_n;
      ready_en  <= 1'b1;
      mem_we    <= mem_we_n;
      mem_addr  <= mem_addr_n;
      mem_wdata <= mem_wdata_n;
      cpu_hold  <= cpu_hold_n;
      load_done <= load_done_n;
      load_err  <= load_err_n;
`ifdef Y86_LOADER_CHECKSUM_EN
      sum       <= sum_n;
`endif
    end
  end

endmodule

// File: tb/tb_y86_iram_loader.sv
// Directed bench for y86_iram_loader: scoreboarded IRAM writes, backpressure, range error, mid-frame reset,
// and (with Y86_LOADER_CHECKSUM_EN) checksum handling.
module tb_y86_iram_loader;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ready;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;

  int passed = 0;
  int failed = 0;
  int total = 0;
  int write_count = 0;
  int done_count = 0;
  int stall_seen = 0;
  int stall_left = 0;
  int saved_writes;
  int saved_done;
  logic        hold_at_done = 1'b1;
  logic [39:0] sb[$];
  logic [39:0] exp_w;
  logic [7:0]  payload [0:2];
`ifdef Y86_LOADER_CHECKSUM_EN
  logic [7:0]  csum_delta = 8'd0;
`endif

  localparam logic [31:0] STALL_ADDR = 32'h0000_0101;

  always #5 CLK = ~CLK;

  y86_iram_loader dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .cpu_hold  (cpu_hold),
    .load_done (load_done),
    .load_err  (load_err)
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one byte and hold it until the loader takes it, bounded so a stuck rx_ready cannot hang the run.
  task automatic applyStimulus(input logic [7:0] b);
    int waited;
    waited = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge CLK);
    while (rx_ready !== 1'b1 && waited < 50) begin
      waited++;
      @(negedge CLK);
    end
    if (rx_ready !== 1'b1)
      checkOutput("rx_accept", 64'(rx_ready), 64'd1);
    @(posedge CLK);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic sendHeader(input logic [31:0] base, input logic [15:0] len);
    applyStimulus(8'hA5);
    for (int i = 0; i < 4; i++)
      applyStimulus(base[8*i +: 8]);
    applyStimulus(len[7:0]);
    applyStimulus(len[15:8]);
  endtask

  task automatic sendFrame(input logic [31:0] base, input bit expect_writes);
`ifdef Y86_LOADER_CHECKSUM_EN
    logic [7:0] csum;
    csum = 8'd0;
`endif
    sendHeader(base, 16'd3);
    for (int i = 0; i < 3; i++) begin
      if (expect_writes)
        sb.push_back({base + 32'(i), payload[i]});
`ifdef Y86_LOADER_CHECKSUM_EN
      csum = csum + payload[i];
`endif
      applyStimulus(payload[i]);
    end
`ifdef Y86_LOADER_CHECKSUM_EN
    applyStimulus(csum + csum_delta);
`endif
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic resetDut();
    RESET = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b0;
    @(posedge CLK);
    #1;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_rx_ready"},  64'(rx_ready),  64'd0);
    checkOutput({tag, "_mem_we"},    64'(mem_we),    64'd0);
    checkOutput({tag, "_mem_addr"},  64'(mem_addr),  64'd0);
    checkOutput({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
    checkOutput({tag, "_cpu_hold"},  64'(cpu_hold),  64'd1);
    checkOutput({tag, "_load_done"}, 64'(load_done), 64'd0);
    checkOutput({tag, "_load_err"},  64'(load_err),  64'd0);
  endtask

  // IRAM model: injects a fixed stall on one address, otherwise always ready.
  initial begin
    mem_ready = 1'b1;
    forever begin
      @(posedge CLK);
      #2;
      if (mem_we === 1'b1 && mem_addr === STALL_ADDR && stall_left > 0) begin
        mem_ready = 1'b0;
        stall_left--;
      end else begin
        mem_ready = 1'b1;
      end
    end
  end

  // Completed writes are popped against the scoreboard; stalled writes must hold steady.
  always @(negedge CLK) begin
    if (mem_we === 1'b1 && mem_ready === 1'b1) begin
      write_count++;
      if (sb.size() == 0) begin
        checkOutput("write_expected", 64'(sb.size()), 64'd1);
      end else begin
        exp_w = sb.pop_front();
        checkOutput("iram_write", 64'({mem_addr, mem_wdata}), 64'(exp_w));
      end
    end
    if (mem_we === 1'b1 && mem_ready === 1'b0) begin
      stall_seen++;
      checkOutput("stall_addr",     64'(mem_addr),  64'(STALL_ADDR));
      checkOutput("stall_data",     64'(mem_wdata), 64'h00F0);
      checkOutput("stall_rx_ready", 64'(rx_ready),  64'd0);
    end
    if (load_done === 1'b1) begin
      done_count++;
      hold_at_done = cpu_hold;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    RESET    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    payload[0] = 8'h30;
    payload[1] = 8'hF0;
    payload[2] = 8'h10;

    repeat (2) @(posedge CLK);
    @(negedge CLK);
    checkResetValues("por");
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    @(negedge CLK);
    checkOutput("rx_ready_first_cycle", 64'(rx_ready), 64'd0);
    @(negedge CLK);
    checkOutput("rx_ready_after_reset", 64'(rx_ready), 64'd1);
    @(posedge CLK);
    #1;

    $display("[TB] basic load");
    checkOutput("hold_before_first", 64'(cpu_hold), 64'd1);
    sendFrame(32'h0000_0100, 1'b1);
    waitCycles(8);
    checkOutput("basic_done_count", 64'(done_count),   64'd1);
    checkOutput("basic_hold_at_done", 64'(hold_at_done), 64'd0);
    checkOutput("basic_cpu_hold",   64'(cpu_hold),     64'd0);
    checkOutput("basic_load_err",   64'(load_err),     64'd0);
    checkOutput("basic_sb_drained", 64'(sb.size()),    64'd0);

    $display("[TB] garbage before sync");
    applyStimulus(8'h00);
    applyStimulus(8'hFF);
    applyStimulus(8'h5A);
    sendFrame(32'h0000_0100, 1'b1);
    waitCycles(8);
    checkOutput("garbage_done_count", 64'(done_count), 64'd2);
    checkOutput("garbage_load_err",   64'(load_err),   64'd0);
    checkOutput("garbage_cpu_hold",   64'(cpu_hold),   64'd0);
    checkOutput("garbage_sb_drained", 64'(sb.size()),  64'd0);

    $display("[TB] backpressure");
    stall_left = 5;
    sendFrame(32'h0000_0100, 1'b1);
    waitCycles(8);
    checkOutput("bp_stall_cycles", 64'(stall_seen), 64'd5);
    checkOutput("bp_done_count",   64'(done_count), 64'd3);
    checkOutput("bp_sb_drained",   64'(sb.size()),  64'd0);
    checkOutput("bp_load_err",     64'(load_err),   64'd0);

    $display("[TB] reset mid-DATA");
    sendHeader(32'h0000_0200, 16'd3);
    sb.push_back({32'h0000_0200, 8'h30});
    applyStimulus(8'h30);
    RESET = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    checkResetValues("mid_reset");
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    waitCycles(2);
    checkOutput("mid_reset_hold", 64'(cpu_hold), 64'd1);
    hold_at_done = 1'b1;
    sendFrame(32'h0000_0200, 1'b1);
    waitCycles(8);
    checkOutput("reload_done_count",  64'(done_count),   64'd4);
    checkOutput("reload_hold_at_done", 64'(hold_at_done), 64'd0);
    checkOutput("reload_cpu_hold",    64'(cpu_hold),     64'd0);
    checkOutput("reload_sb_drained",  64'(sb.size()),    64'd0);

`ifdef Y86_LOADER_CHECKSUM_EN
    $display("[TB] checksum error");
    resetDut();
    saved_done = done_count;
    csum_delta = 8'd1;
    sendFrame(32'h0000_0100, 1'b1);
    waitCycles(8);
    csum_delta = 8'd0;
    checkOutput("csum_load_err",   64'(load_err),   64'd1);
    checkOutput("csum_no_done",    64'(done_count), 64'(saved_done));
    checkOutput("csum_cpu_hold",   64'(cpu_hold),   64'd1);
    checkOutput("csum_sb_drained", 64'(sb.size()),  64'd0);
`endif

    $display("[TB] range error");
    resetDut();
    saved_writes = write_count;
    saved_done   = done_count;
    sendHeader(32'h0000_0F00, 16'h0200);
    waitCycles(4);
    checkOutput("range_load_err", 64'(load_err),    64'd1);
    checkOutput("range_cpu_hold", 64'(cpu_hold),    64'd1);
    checkOutput("range_mem_we",   64'(mem_we),      64'd0);
    checkOutput("range_writes",   64'(write_count), 64'(saved_writes));
    sendFrame(32'h0000_0100, 1'b0);
    waitCycles(8);
    checkOutput("after_err_writes",   64'(write_count), 64'(saved_writes));
    checkOutput("after_err_done",     64'(done_count),  64'(saved_done));
    checkOutput("after_err_load_err", 64'(load_err),    64'd1);
    checkOutput("after_err_cpu_hold", 64'(cpu_hold),    64'd1);

    checkOutput("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/y86_iram_loader.md
Name: y86_iram_loader

Overview:
- Byte-stream writer for the y86 instruction RAM. It parses framed load records from a host byte channel and issues byte writes into IRAM.
- Holds the CPU in reset until the first frame loads successfully, so simulation and board builds can boot programs without a hex file.
- Sits between the host/UART byte source and the IRAM write port. It is the write-side counterpart to the CPU's fetch path.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- ADDR_LIMIT, 32'h0000_1000, size of IRAM in bytes; writes must satisfy base+len <= ADDR_LIMIT.

Ports:
- CLK  in  1  system clock
- RESET  in  1  synchronous, active-high reset
- rx_data  in  8  incoming byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  loader accepts byte this cycle (transfer = rx_valid & rx_ready)
- mem_we  out  1  IRAM byte write strobe
- mem_addr  out  32  IRAM byte address
- mem_wdata  out  8  IRAM write byte
- mem_ready  in  1  IRAM accepted write (write completes when mem_we & mem_ready)
- cpu_hold  out  1  drive CPU RESET; high until first successful frame
- load_done  out  1  one-cycle pulse on frame completion
- load_err  out  1  sticky error flag

Behaviour:
- Reset values: rx_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=1, load_done=0, load_err=0, state=IDLE. rx_ready rises in the first cycle after RESET deasserts.
- Frame format, little-endian fields: SYNC, ADDR[4 bytes], LEN[2 bytes], LEN payload bytes, CSUM[1 byte, optional].
- FSM states: IDLE, ADDR, LEN, DATA, CSUM, DONE, ERR. A 2-bit byte counter is used in ADDR and LEN.
- IDLE: an accepted byte equal to SYNC_BYTE goes to ADDR. Any other byte is silently dropped and the FSM stays in IDLE.
- ADDR: 4 accepted bytes assemble the base address, then go to LEN.
- LEN: 2 accepted bytes assemble len.
  - If base+len > ADDR_LIMIT (33-bit compare, no wrap), go to ERR.
  - Else if len==0, go to CSUM (feature on) or DONE (feature off).
  - Else go to DATA.
- DATA, each accepted byte:
  - Registers mem_addr=base+index and mem_wdata=byte, and asserts mem_we the next cycle. Index starts at 0.
  - Adds the byte to an 8-bit running sum (mod 256).
  - Decrements the remaining count.
  - mem_we holds with stable addr/data until mem_ready=1, then drops the following cycle unless a new byte is queued.
  - rx_ready=0 while a write is pending and mem_ready=0. At most one outstanding write.
  - After the last byte's write completes, go to CSUM or DONE.
- CSUM: one accepted byte is compared to the running sum. Match goes to DONE; mismatch goes to ERR.
- DONE (1 cycle): load_done=1, cpu_hold cleared to 0 permanently until RESET, sum and counters cleared, then return to IDLE. Later frames reload memory while the CPU keeps running; cpu_hold stays 0.
- ERR:
  - load_err=1, sticky until RESET.
  - rx_ready=1 and all bytes are dropped; no further writes.
  - cpu_hold keeps its current value. If the error is on the first frame, the CPU stays held.
- RESET mid-frame: abandons the frame immediately. A pending mem_we deasserts next edge. Partial writes already completed are not undone.
- rx_valid with rx_ready=0: no transfer. The source must hold the byte.
- Outputs are registered. No combinational path from rx_* to mem_*. Only rx_ready depends combinationally on mem_ready.

Optional Feature:
- Macro Y86_LOADER_CHECKSUM_EN.
- Defined: a CSUM byte follows every payload and is checked as above; a mismatch sets load_err.
- Undefined: no CSUM byte is expected. The FSM goes from DATA (or LEN when len==0) straight to DONE. The CSUM state and running sum are not synthesized.

Test Plan:
- Basic load: A5 00 01 00 00 03 00 30 F0 10 [CSUM=0x30] with mem_ready=1 ->
  - writes 0x100=30, 0x101=F0, 0x102=10
  - load_done pulses once
  - cpu_hold falls the same cycle; load_err=0
- Garbage before sync: 00 FF 5A then the basic frame -> leading bytes dropped, identical writes and result to the basic load.
- Backpressure: hold mem_ready=0 for 5 cycles on the second payload byte ->
  - mem_we/addr 0x101/data F0 stay stable
  - rx_ready=0 throughout
  - no byte is lost
- Range error: A5 00 0F 00 00 00 02 with ADDR_LIMIT=0x1000 (0xF00+0x200 > 0x1000) ->
  - ERR, load_err=1, no mem_we, cpu_hold stays 1
  - a following valid frame is ignored
- Checksum error (feature on): basic frame with CSUM=0x31 -> all three writes occur, then load_err=1, no load_done, cpu_hold=1.
- Reset mid-DATA: assert RESET after the first payload byte ->
  - all outputs return to reset values next cycle
  - a new full frame loads correctly and releases cpu_hold
